// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: LFSR tap table,
// stream length helper and the converter state encoding.
package sc_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } sc_state_e;

  localparam int unsigned LFSR_MIN_W = 3;
  localparam int unsigned LFSR_MAX_W = 16;

  // Feedback tap masks (bit i set = state bit i feeds the XOR) for maximal-length
  // Fibonacci LFSRs that shift left and insert the feedback into bit 0.
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  function automatic int unsigned stream_len(input int unsigned p);
    return (32'd1 << p) - 32'd1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input int unsigned w);
    logic        fb;
    logic [15:0] nxt;
    fb  = ^(s & lfsr_taps(w));
    nxt = {s[14:0], fb};
    return nxt & 16'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous reload to SEED.
// load wins over step so a reseed is never lost to a concurrent advance.
module sc_lfsr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);
  import sc_pkg::*;

  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("sc_lfsr: WIDTH must be in 3..16");
  end
  if (SEED == 0 || SEED > stream_len(WIDTH)) begin : g_bad_seed
    $error("sc_lfsr: SEED must be nonzero and fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = WIDTH'(lfsr_step(16'(state_q), WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED_W;
    end else if (load) begin
      state_q <= SEED_W;
    end else if (step) begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ds_converter.sv
// Digital-to-stochastic converter: turns a PRECISION-bit value into a
// 2^PRECISION-1 bit unipolar stream holding exactly `value` ones.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a value, in_ready=1, no output beat
//   ST_STREAM | presenting beats; last transfer returns to idle or reloads
module ds_converter #(
  parameter int unsigned PRECISION = 8,
  parameter int unsigned SEED      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out,
  output logic                 out_last
);
  import sc_pkg::*;

  if (PRECISION < LFSR_MIN_W || PRECISION > LFSR_MAX_W) begin : g_bad_precision
    $error("ds_converter: PRECISION must be in 3..16");
  end
  if (SEED == 0 || SEED > stream_len(PRECISION)) begin : g_bad_seed
    $error("ds_converter: SEED must be nonzero and below 2^PRECISION");
  end

  localparam int unsigned          N         = stream_len(PRECISION);
  localparam logic [PRECISION-1:0] SEED_W    = PRECISION'(SEED);
  localparam logic [PRECISION-1:0] LAST_BEAT = PRECISION'(N - 1);

  sc_state_e            state_q;
  logic [PRECISION-1:0] value_q;
  logic [PRECISION-1:0] beat_q;
  logic                 out_q;
  logic                 last_q;

  logic [PRECISION-1:0] lfsr_state;
  logic [PRECISION-1:0] lfsr_nxt;
  logic                 xfer;
  logic                 accept;

  assign out_valid = (state_q == ST_STREAM);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = (state_q == ST_IDLE) | (xfer & last_q);
  assign accept    = in_valid & in_ready;

  // Registered output needs the comparison for the beat after this one.
  assign lfsr_nxt  = PRECISION'(lfsr_step(16'(lfsr_state), PRECISION));

  sc_lfsr #(
    .WIDTH (PRECISION),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (xfer),
    .state (lfsr_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      beat_q  <= '0;
      out_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_STREAM;
            value_q <= in_data;
            beat_q  <= '0;
            out_q   <= (SEED_W <= in_data);
            last_q  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (last_q) begin
              if (in_valid) begin
                value_q <= in_data;
                beat_q  <= '0;
                out_q   <= (SEED_W <= in_data);
                last_q  <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                out_q   <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
              out_q  <= (lfsr_nxt <= value_q);
              last_q <= ((beat_q + 1'b1) == LAST_BEAT);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out      = out_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_ds_converter.sv
// Self-checking bench for ds_converter: stream length, ones count, last flag,
// stall stability, back-to-back reload, reset abort and reseed determinism.
module tb_ds_converter;

  localparam int N4 = 15;
  localparam int N8 = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, in_valid4, in_ready4, out_valid4, out_ready4, out4, last4;
  logic [3:0] in_data4;
  logic       rst8, in_valid8, in_ready8, out_valid8, out_ready8, out8, last8;
  logic [7:0] in_data8;

  ds_converter #(.PRECISION(4), .SEED(1)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out(out4), .out_last(last4)
  );

  ds_converter #(.PRECISION(8), .SEED(8'hA5)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .out_last(last8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Results of the most recent collected stream on the 4-bit converter.
  logic [N4-1:0] bits4;
  int ones4, beats4, lastcnt4, lastpos4, stall_bad4, gap4, rdy_bad4;

  task automatic send4(input int v);
    in_valid4 = 1'b1;
    in_data4  = 4'(v);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    in_data4  = 4'($urandom);
  endtask

  // Collect up to maxb transfers. Stalls either at fixed beat indices
  // (3 cycles each) or randomly. Optionally drops in_valid after the last beat.
  task automatic collect4(input int sa, input int sb, input bit rnd,
                          input bit drop_on_last, input int maxb);
    int   st, cyc;
    bit   stalled;
    logic ho, hl;
    bits4 = '0; ones4 = 0; beats4 = 0; lastcnt4 = 0; lastpos4 = 0;
    stall_bad4 = 0; gap4 = 0; rdy_bad4 = 0; st = 0; cyc = 0;
    ho = 1'b0; hl = 1'b0;
    while (beats4 < maxb && cyc < 400) begin
      if (rnd) stalled = ($urandom_range(3) == 0);
      else     stalled = ((beats4 == sa || beats4 == sb) && st < 3);
      out_ready4 = !stalled;
      #1;
      if (out_valid4 !== 1'b1) begin
        gap4++;
      end else begin
        if (st > 0 && (out4 !== ho || last4 !== hl)) stall_bad4++;
        if (st == 0) begin ho = out4; hl = last4; end
        if (in_ready4 !== (last4 & !stalled)) rdy_bad4++;
        if (!stalled) begin
          bits4[beats4] = out4;
          ones4 += (out4 === 1'b1) ? 1 : 0;
          if (last4 === 1'b1) begin lastcnt4++; lastpos4 = beats4 + 1; end
          beats4++;
          st = 0;
        end else begin
          st++;
        end
      end
      @(posedge clk); #1;
      if (drop_on_last && lastcnt4 > 0) in_valid4 = 1'b0;
      cyc++;
    end
    out_ready4 = 1'b1;
  endtask

  task automatic check_stream4(input string tag, input int v);
    chk({tag, "_beats"},   beats4,     N4);
    chk({tag, "_ones"},    ones4,      v);
    chk({tag, "_lastcnt"}, lastcnt4,   1);
    chk({tag, "_lastpos"}, lastpos4,   N4);
    chk({tag, "_gap"},     gap4,       0);
    chk({tag, "_stall"},   stall_bad4, 0);
    chk({tag, "_inrdy"},   rdy_bad4,   0);
  endtask

  task automatic check_idle4(input string tag);
    chk({tag, "_oval"},  out_valid4, 0);
    chk({tag, "_inrdy"}, in_ready4,  1);
  endtask

  task automatic run8(input int v, input string tag);
    int ones, beats, lastcnt, lastpos, cyc;
    ones = 0; beats = 0; lastcnt = 0; lastpos = 0; cyc = 0;
    in_valid8 = 1'b1;
    in_data8  = 8'(v);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_data8  = 8'($urandom);
    while (beats < N8 && cyc < 1500) begin
      out_ready8 = ($urandom_range(4) != 0);
      #1;
      if (out_valid8 === 1'b1 && out_ready8) begin
        ones += (out8 === 1'b1) ? 1 : 0;
        if (last8 === 1'b1) begin lastcnt++; lastpos = beats + 1; end
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready8 = 1'b1;
    chk({tag, "_beats"},   beats,   N8);
    chk({tag, "_ones"},    ones,    v);
    chk({tag, "_lastpos"}, lastpos, N8);
    chk({tag, "_lastcnt"}, lastcnt, 1);
    chk({tag, "_idle"},    out_valid8, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N4-1:0] saved, lo_bits;
    int a, b, lo, hi;

    rst4 = 1'b1; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
    rst8 = 1'b1; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oval",  out_valid4, 0);
    chk("rst_out",   out4,       0);
    chk("rst_last",  last4,      0);
    chk("rst_inrdy", in_ready4,  1);
    rst4 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    // Boundaries: all zeros and all ones.
    send4(0);  collect4(-1, -1, 0, 0, N4); check_stream4("v0", 0);   check_idle4("v0_end");
    send4(15); collect4(-1, -1, 0, 0, N4); check_stream4("v15", 15); check_idle4("v15_end");

    // Reseed: identical bit sequence on a repeat of the same value.
    send4(5); collect4(-1, -1, 0, 0, N4); check_stream4("v5a", 5); saved = bits4;
    send4(5); collect4(-1, -1, 0, 0, N4); check_stream4("v5b", 5);
    chk("reseed_bits", bits4, saved);

    // Fixed stalls at beats 4 and 10.
    send4(9); collect4(3, 9, 0, 0, N4); check_stream4("stall9", 9);

    // Back-to-back: second value held on in_valid, taken on the last transfer.
    in_valid4 = 1'b1; in_data4 = 4'd3;
    @(posedge clk); #1;
    in_data4 = 4'd12;
    collect4(-1, -1, 0, 1, N4); check_stream4("b2b_a", 3);
    collect4(-1, -1, 0, 0, N4); check_stream4("b2b_b", 12);
    check_idle4("b2b_end");

    // Reset at beat 7 aborts the stream asynchronously.
    send4(10); collect4(-1, -1, 0, 0, 6);
    chk("abort_pre_oval", out_valid4, 1);
    rst4 = 1'b1; #1;
    chk("abort_oval", out_valid4, 0);
    chk("abort_last", last4,      0);
    @(posedge clk); #1;
    rst4 = 1'b0; #1;
    chk("abort_inrdy", in_ready4, 1);
    @(posedge clk); #1;
    send4(2); collect4(-1, -1, 0, 0, N4); check_stream4("post_rst", 2);

    // Random values with random backpressure; thresholding a fixed sequence
    // means the ones of a smaller value are a subset of a larger one's.
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(15); b = $urandom_range(15);
      lo = (a < b) ? a : b; hi = (a < b) ? b : a;
      send4(lo); collect4(-1, -1, 1, 0, N4); check_stream4("rnd_lo", lo); lo_bits = bits4;
      send4(hi); collect4(-1, -1, 1, 0, N4); check_stream4("rnd_hi", hi);
      chk("rnd_subset", lo_bits & ~bits4, 0);
    end

    // 8-bit converter with nondefault seed.
    run8(0, "p8_v0");
    run8(255, "p8_v255");
    for (int k = 0; k < 5; k++) run8($urandom_range(255), "p8_rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
